reg_write_scoreboard: RTL and testbench

//  Producer-side hazard tracker for the dual-issue pipeline. Records every in-flight

---
 rtl/reg_write_scoreboard.sv | 115 +++++++++++
 tb/tb_reg_write_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scoreboard.sv
// Tracks in-flight register writes from issue to write-back/kill and their forwarding countdowns.
// Queries are combinational from registered state; pending_mask/errors update on the edge.
// No backpressure: every issue/wb/kill event is accepted each cycle.
module reg_write_scoreboard #(
  parameter int CNT_W     = 3,
  parameter int LAT_W     = 2,
  parameter int LAT_ALU   = 1,
  parameter int LAT_MEM   = 2,
  parameter int NUM_QUERY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             iss_valid,
  input  logic [9:0]             iss_dest,
  input  logic [1:0]             iss_is_load,
  input  logic [1:0]             wb_valid,
  input  logic [9:0]             wb_dest,
  input  logic [1:0]             kill_valid,
  input  logic [9:0]             kill_dest,
  input  logic [NUM_QUERY*5-1:0] q_reg,
  output logic [NUM_QUERY-1:0]   q_pending,
  output logic [NUM_QUERY-1:0]   q_stall,
  output logic [31:0]            pending_mask,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] count_q [32];
  logic [CNT_W-1:0] count_d [32];
  logic [LAT_W-1:0] cd_q    [32];
  logic [LAT_W-1:0] cd_d    [32];
  logic [31:0]      mask_d;
  logic             ovf_d;
  logic             unf_d;

  always_comb begin
    int               net;
    logic             iss_hit;
    logic [LAT_W-1:0] load_val;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    mask_d   = '0;
    net      = 0;
    iss_hit  = 1'b0;
    load_val = '0;
    for (int r = 0; r < 32; r++) begin
      count_d[r] = count_q[r];
      cd_d[r]    = cd_q[r];
    end
    // Register 0 is never tracked, so its entry stays at its reset value.
    for (int r = 1; r < 32; r++) begin
      net      = int'(count_q[r]);
      iss_hit  = 1'b0;
      load_val = '0;
      for (int s = 0; s < 2; s++) begin
        if (iss_valid[s] && iss_dest[5*s +: 5] == 5'(r)) begin
          net      = net + 1;
          iss_hit  = 1'b1;
          load_val = iss_is_load[s] ? LAT_W'(LAT_MEM) : LAT_W'(LAT_ALU);
        end
        if (wb_valid[s] && wb_dest[5*s +: 5] == 5'(r)) net = net - 1;
        if (kill_valid[s] && kill_dest[5*s +: 5] == 5'(r)) net = net - 1;
      end
      if (net > CNT_MAX) begin
        count_d[r] = CNT_W'(CNT_MAX);
        ovf_d      = 1'b1;
      end else if (net < 0) begin
        count_d[r] = '0;
        unf_d      = 1'b1;
      end else begin
        count_d[r] = CNT_W'(net);
      end
      // Slot 1 is iterated last, so the younger writer's latency wins.
      if (count_d[r] == '0)      cd_d[r] = '0;
      else if (iss_hit)          cd_d[r] = load_val;
      else if (cd_q[r] != '0)    cd_d[r] = cd_q[r] - 1'b1;
      mask_d[r] = (count_d[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        count_q[r] <= '0;
        cd_q[r]    <= '0;
      end
      pending_mask  <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        count_q[r] <= count_d[r];
        cd_q[r]    <= cd_d[r];
      end
      pending_mask  <= mask_d;
      err_overflow  <= err_overflow | ovf_d;
      err_underflow <= err_underflow | unf_d;
    end
  end

  always_comb begin
    logic [4:0] qr;
    qr        = '0;
    q_pending = '0;
    q_stall   = '0;
    for (int q = 0; q < NUM_QUERY; q++) begin
      qr           = q_reg[5*q +: 5];
      q_pending[q] = (count_q[qr] != '0);
      q_stall[q]   = (count_q[qr] != '0) && (cd_q[qr] != '0);
    end
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed and random checks of reg_write_scoreboard against a per-register
// in-flight-count / absolute-ready-cycle reference model.
module tb_reg_write_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  iss_valid, iss_is_load, wb_valid, kill_valid;
  logic [9:0]  iss_dest, wb_dest, kill_dest;
  logic [19:0] q_reg;
  logic [3:0]  q_pending, q_stall;
  logic [31:0] pending_mask;
  logic        err_overflow, err_underflow;

  reg_write_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_is_load(iss_is_load),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .kill_valid(kill_valid), .kill_dest(kill_dest),
    .q_reg(q_reg), .q_pending(q_pending), .q_stall(q_stall),
    .pending_mask(pending_mask),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0, nfail = 0;
  // Model: outstanding writes per register, and the first cycle at which the
  // youngest writer is forwardable.
  int cnt [32];
  int rdy_at [32];
  bit m_ovf, m_unf;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      cnt[r] = 0;
      rdy_at[r] = 0;
    end
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic idle();
    iss_valid = '0; iss_dest = '0; iss_is_load = '0;
    wb_valid = '0; wb_dest = '0; kill_valid = '0; kill_dest = '0;
  endtask

  task automatic tick();
    int nc [32];
    int nr [32];
    int net, lat;
    bit hit;
    for (int r = 0; r < 32; r++) begin
      nc[r] = cnt[r];
      nr[r] = rdy_at[r];
    end
    for (int r = 1; r < 32; r++) begin
      net = cnt[r]; hit = 0; lat = 0;
      for (int s = 0; s < 2; s++) begin
        if (iss_valid[s] && iss_dest[5*s +: 5] == 5'(r)) begin
          net++; hit = 1; lat = iss_is_load[s] ? 2 : 1;
        end
        if (wb_valid[s] && wb_dest[5*s +: 5] == 5'(r)) net--;
        if (kill_valid[s] && kill_dest[5*s +: 5] == 5'(r)) net--;
      end
      if (net > 7) begin net = 7; m_ovf = 1; end
      else if (net < 0) begin net = 0; m_unf = 1; end
      nc[r] = net;
      if (net == 0) nr[r] = 0;
      else if (hit) nr[r] = cyc + 1 + lat;
    end
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin
      cnt[r] = nc[r];
      rdy_at[r] = nr[r];
    end
    cyc++;
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] d);
    logic [4:0]  rq [4];
    logic [31:0] em;
    bit          pend, st;
    rq[0] = a; rq[1] = b; rq[2] = c; rq[3] = d;
    q_reg = {d, c, b, a};
    #1;
    for (int i = 0; i < 4; i++) begin
      pend = (rq[i] != 0) && (cnt[rq[i]] != 0);
      st   = pend && (cyc < rdy_at[rq[i]]);
      chk($sformatf("%s_pend%0d_r%0d", tag, i, rq[i]), 32'(q_pending[i]), 32'(pend));
      chk($sformatf("%s_stall%0d_r%0d", tag, i, rq[i]), 32'(q_stall[i]), 32'(st));
    end
    em = '0;
    for (int r = 1; r < 32; r++) em[r] = (cnt[r] != 0);
    chk({tag, "_mask"}, pending_mask, em);
    chk({tag, "_ovf"}, 32'(err_overflow), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(err_underflow), 32'(m_unf));
  endtask

  initial begin
    idle();
    q_reg = '0;
    reset = 1'b1;
    model_reset();
    #12;
    check_regs("rst", 5, 8, 3, 9);
    @(negedge clk);
    reset = 1'b0;

    // 1: single ALU write, one stall cycle, retire
    iss_valid = 2'b01; iss_dest = {5'd0, 5'd5};
    tick(); idle();
    check_regs("t1a", 5, 0, 6, 4);
    chk("t1a_lit_stall", 32'(q_stall[0]), 32'd1);
    tick();
    check_regs("t1b", 5, 5, 0, 0);
    chk("t1b_lit_stall", 32'(q_stall[0]), 32'd0);
    wb_valid = 2'b01; wb_dest = {5'd0, 5'd5};
    tick(); idle();
    check_regs("t1c", 5, 0, 0, 0);
    chk("t1c_lit_mask5", 32'(pending_mask[5]), 32'd0);

    // 2: dual issue to same reg, younger is a load
    iss_valid = 2'b11; iss_dest = {5'd8, 5'd8}; iss_is_load = 2'b10;
    tick(); idle();
    check_regs("t2a", 8, 8, 0, 5);
    tick();
    check_regs("t2b", 8, 0, 0, 0);
    chk("t2b_lit_stall", 32'(q_stall[0]), 32'd1);
    wb_valid = 2'b01; wb_dest = {5'd0, 5'd8};
    tick(); idle();
    check_regs("t2c", 8, 0, 0, 0);
    wb_valid = 2'b10; wb_dest = {5'd8, 5'd0};
    tick(); idle();
    check_regs("t2d", 8, 0, 0, 0);
    chk("t2d_lit_pend", 32'(q_pending[0]), 32'd0);

    // 3: issue and wb to same reg in one cycle
    iss_valid = 2'b01; iss_dest = {5'd0, 5'd3};
    tick(); idle();
    tick(); tick();
    check_regs("t3a", 3, 0, 0, 0);
    iss_valid = 2'b01; iss_dest = {5'd0, 5'd3}; iss_is_load = 2'b01;
    wb_valid = 2'b10; wb_dest = {5'd3, 5'd0};
    tick(); idle();
    check_regs("t3b", 3, 3, 0, 0);

    // 4: register 0 is never tracked
    iss_valid = 2'b11; iss_dest = '0;
    kill_valid = 2'b11; kill_dest = '0; wb_valid = 2'b01; wb_dest = '0;
    tick(); idle();
    check_regs("t4", 0, 0, 0, 0);

    // 5: overflow on reg 9, underflow on reg 10
    repeat (4) begin
      iss_valid = 2'b11; iss_dest = {5'd9, 5'd9};
      tick();
    end
    idle();
    check_regs("t5a", 9, 10, 0, 0);
    chk("t5a_lit_ovf", 32'(err_overflow), 32'd1);
    wb_valid = 2'b01; wb_dest = {5'd0, 5'd10};
    tick(); idle();
    check_regs("t5b", 9, 10, 0, 0);
    chk("t5b_lit_unf", 32'(err_underflow), 32'd1);

    // 6: asynchronous reset mid-run
    iss_valid = 2'b11; iss_dest = {5'd12, 5'd11}; iss_is_load = 2'b11;
    tick();
    iss_dest = {5'd14, 5'd13};
    tick(); idle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_regs("t6a", 11, 12, 13, 14);
    @(negedge clk);
    reset = 1'b0;
    iss_valid = 2'b01; iss_dest = {5'd0, 5'd4};
    tick(); idle();
    check_regs("t6b", 4, 11, 9, 0);

    // Random traffic on a small register window to force collisions
    for (int it = 0; it < 400; it++) begin
      iss_valid   = 2'($urandom_range(0, 3));
      iss_dest    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iss_is_load = 2'($urandom_range(0, 3));
      wb_valid    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0)};
      wb_dest     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      kill_valid  = {1'b0, ($urandom_range(0, 5) == 0)};
      kill_dest   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick(); idle();
      check_regs("rnd", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (it == 200) begin
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_regs("rnd_rst", 1, 2, 3, 4);
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
